// File: rtl/cdc_pkg.sv
// Shared constants for the multi-channel edge synchroniser.
// Edge-mode encodings and the filter counter width.
package cdc_pkg;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;

  localparam int FILT_W = 8;

endpackage

// File: rtl/cdc_sync_edge_ch.sv
// One channel: sync chain, optional debounce (CDC_SYNC_FILTER_EN),
// edge detect and sticky pending/overflow flags.
module cdc_sync_edge_ch
  import cdc_pkg::*;
#(
  parameter int STAGES    = 2,
  parameter int EDGE_MODE = EDGE_RISE,
  parameter int FILT_CYC  = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  input  logic clr_i,
  output logic level_o,
  output logic pulse_o,
  output logic pending_o,
  output logic ovf_o
);

  if (STAGES < 2 || FILT_CYC < 1 || FILT_CYC > 255 ||
      EDGE_MODE < EDGE_RISE || EDGE_MODE > EDGE_BOTH) begin : g_bad_cfg
    $error("cdc_sync_edge_ch: parameter out of range");
  end

  logic [STAGES-1:0] sync_q;
  logic              filt_lvl;
  logic              prev_q;
  logic              pend_q;
  logic              ovf_q;
  logic              rise;
  logic              fall;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
    end
  end

`ifdef CDC_SYNC_FILTER_EN
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILT_CYC - 1);

  logic [FILT_W-1:0] cnt_q;
  logic              filt_q;

  // Level flips only after FILT_CYC consecutive disagreeing cycles.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else if (sync_q[STAGES-1] != filt_q) begin
      if (cnt_q == FILT_LAST) begin
        cnt_q  <= '0;
        filt_q <= ~filt_q;
      end else begin
        cnt_q <= cnt_q + FILT_W'(1);
      end
    end else begin
      cnt_q <= '0;
    end
  end

  assign filt_lvl = filt_q;
`else
  assign filt_lvl = sync_q[STAGES-1];
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= filt_lvl;
    end
  end

  assign rise = filt_lvl & ~prev_q;
  assign fall = ~filt_lvl & prev_q;

  always_comb begin
    pulse_o = 1'b0;
    case (EDGE_MODE)
      EDGE_RISE: pulse_o = rise;
      EDGE_FALL: pulse_o = fall;
      default:   pulse_o = rise | fall;
    endcase
  end

  // A new event beats a clear; a clear always drops a stale overflow.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (pulse_o) begin
        pend_q <= 1'b1;
      end else if (clr_i) begin
        pend_q <= 1'b0;
      end
      if (clr_i) begin
        ovf_q <= 1'b0;
      end else if (pulse_o && pend_q) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign level_o   = filt_lvl;
  assign pending_o = pend_q;
  assign ovf_o     = ovf_q;

endmodule

// File: rtl/cdc_sync_edge_multi.sv
// CH independent level synchronisers with edge pulses and sticky flags.
// Optional debounce filter compiled in with CDC_SYNC_FILTER_EN.
module cdc_sync_edge_multi
  import cdc_pkg::*;
#(
  parameter int CH        = 4,
  parameter int STAGES    = 2,
  parameter int EDGE_MODE = EDGE_RISE,
  parameter int FILT_CYC  = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [CH-1:0] async_i,
  input  logic [CH-1:0] clr_i,
  output logic [CH-1:0] level_o,
  output logic [CH-1:0] pulse_o,
  output logic [CH-1:0] pending_o,
  output logic [CH-1:0] ovf_o
);

  if (CH < 1 || CH > 32) begin : g_bad_ch
    $error("cdc_sync_edge_multi: CH out of range");
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    cdc_sync_edge_ch #(
      .STAGES   (STAGES),
      .EDGE_MODE(EDGE_MODE),
      .FILT_CYC (FILT_CYC)
    ) u_ch (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .async_i  (async_i[i]),
      .clr_i    (clr_i[i]),
      .level_o  (level_o[i]),
      .pulse_o  (pulse_o[i]),
      .pending_o(pending_o[i]),
      .ovf_o    (ovf_o[i])
    );
  end

endmodule

// File: tb/tb_cdc_sync_edge_multi.sv
// Scoreboard bench: three configurations (rise/S2, both/S2, fall/S3)
// driven in parallel and checked against a cycle history model.
module tb_cdc_sync_edge_multi;

  localparam int FILT = 4;

  typedef struct packed {
    logic [3:0] lv;
    logic [3:0] pu;
    logic [3:0] pe;
    logic [3:0] ov;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [3:0] async_s;
  logic [3:0] clr_s;
  logic [3:0] lv [3];
  logic [3:0] pu [3];
  logic [3:0] pe [3];
  logic [3:0] ov [3];

  int vecs;
  int miss;

  exp_t q [3][$];

  cdc_sync_edge_multi #(
    .CH(4), .STAGES(2), .EDGE_MODE(0), .FILT_CYC(FILT)
  ) u_rise (
    .clk_i(clk), .rst_i(rst), .async_i(async_s), .clr_i(clr_s),
    .level_o(lv[0]), .pulse_o(pu[0]), .pending_o(pe[0]), .ovf_o(ov[0])
  );

  cdc_sync_edge_multi #(
    .CH(4), .STAGES(2), .EDGE_MODE(2), .FILT_CYC(FILT)
  ) u_both (
    .clk_i(clk), .rst_i(rst), .async_i(async_s), .clr_i(clr_s),
    .level_o(lv[1]), .pulse_o(pu[1]), .pending_o(pe[1]), .ovf_o(ov[1])
  );

  cdc_sync_edge_multi #(
    .CH(4), .STAGES(3), .EDGE_MODE(1), .FILT_CYC(FILT)
  ) u_fall (
    .clk_i(clk), .rst_i(rst), .async_i(async_s), .clr_i(clr_s),
    .level_o(lv[2]), .pulse_o(pu[2]), .pending_o(pe[2]), .ovf_o(ov[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int stg(int d);
    return (d == 2) ? 3 : 2;
  endfunction

  function automatic int mode(int d);
    return (d == 0) ? 0 : ((d == 1) ? 2 : 1);
  endfunction

  // Reference model: samples since reset, delayed by the sync depth
  bit [3:0] hist [3][$];
  bit [3:0] m_lv [3];
  bit [3:0] m_pu [3];
  bit [3:0] m_pe [3];
  bit [3:0] m_ov [3];
`ifdef CDC_SYNC_FILTER_EN
  bit [3:0] m_f [3];
  bit [3:0] m_s [3];
  int       m_run [3][4];
`endif

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      hist[d].delete();
      m_lv[d] = '0;
      m_pu[d] = '0;
      m_pe[d] = '0;
      m_ov[d] = '0;
`ifdef CDC_SYNC_FILTER_EN
      m_f[d] = '0;
      m_s[d] = '0;
      for (int b = 0; b < 4; b++) m_run[d][b] = 0;
`endif
    end
  endtask

  task automatic model_edge(bit [3:0] a, bit [3:0] c);
    for (int d = 0; d < 3; d++) begin
      int       n;
      bit [3:0] s;
      bit [3:0] nl;
      bit [3:0] chg;
      bit [3:0] p;
      hist[d].push_back(a);
      n = hist[d].size();
      s = (n >= stg(d)) ? hist[d][n-stg(d)] : 4'b0;
`ifdef CDC_SYNC_FILTER_EN
      for (int b = 0; b < 4; b++) begin
        if (m_s[d][b] != m_f[d][b]) begin
          m_run[d][b]++;
          if (m_run[d][b] == FILT) begin
            m_f[d][b]   = ~m_f[d][b];
            m_run[d][b] = 0;
          end
        end else begin
          m_run[d][b] = 0;
        end
      end
      m_s[d] = s;
      nl = m_f[d];
`else
      nl = s;
`endif
      m_ov[d] = ~c & (m_ov[d] | (m_pu[d] & m_pe[d]));
      m_pe[d] = m_pu[d] | (~c & m_pe[d]);
      chg = nl ^ m_lv[d];
      case (mode(d))
        0:       p = chg & nl;
        1:       p = chg & ~nl;
        default: p = chg;
      endcase
      m_lv[d] = nl;
      m_pu[d] = p;
    end
  endtask

  // One clock: update model for the edge just taken, then drive next inputs
  task automatic step(bit rst_c, bit [3:0] a_n, bit [3:0] c_n, bit tgt);
    exp_t e;
    @(posedge clk);
    #1;
    if (rst_c) begin
      rst = 1'b1;
      model_reset();
    end else if (rst) begin
      rst = 1'b0;
      model_reset();
    end else begin
      model_edge(async_s, clr_s);
    end
    for (int d = 0; d < 3; d++) begin
      e.lv = m_lv[d];
      e.pu = m_pu[d];
      e.pe = m_pe[d];
      e.ov = m_ov[d];
      q[d].push_back(e);
    end
    #2;
    async_s = a_n;
    clr_s   = tgt ? (c_n | m_pu[1]) : c_n;
  endtask

  task automatic hold(int k, bit [3:0] a);
    for (int i = 0; i < k; i++) step(1'b0, a, 4'b0, 1'b0);
  endtask

  task automatic chk(string nm, int d, logic [3:0] got, logic [3:0] want);
    vecs++;
    if (got !== want) begin
      miss++;
      $display("FAIL %s dut%0d t=%0t got=%b want=%b",
               nm, d, $time, got, want);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (q[d].size() > 0) begin
          e = q[d].pop_front();
          chk("level", d, lv[d], e.lv);
          chk("pulse", d, pu[d], e.pu);
          chk("pending", d, pe[d], e.pe);
          chk("ovf", d, ov[d], e.ov);
        end
      end
    end
  end

  initial begin
    bit [3:0] a;
    bit [3:0] c;
    vecs    = 0;
    miss    = 0;
    rst     = 1'b1;
    async_s = 4'b1000;
    clr_s   = 4'b0;
    model_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 4'b1000, 4'b0, 1'b0);
    hold(8, 4'b1000);
    hold(6, 4'b1001);
    hold(5, 4'b1011);
    hold(5, 4'b1001);
    hold(5, 4'b1011);
    hold(6, 4'b1111);
    hold(6, 4'b1011);
    hold(8, 4'b1010);
    hold(3, 4'b1011);
    hold(10, 4'b1010);
    hold(6, 4'b1011);
    hold(10, 4'b1010);
    step(1'b0, 4'b1010, 4'hf, 1'b0);
    hold(4, 4'b1110);
    hold(8, 4'b1010);
    step(1'b0, 4'b0000, 4'b0, 1'b0);
    step(1'b1, 4'b0000, 4'b0, 1'b0);
    step(1'b1, 4'b0000, 4'b0, 1'b0);
    hold(8, 4'b0000);
    a = 4'b0;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 4) == 0) a[b] = ~a[b];
      end
      c = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0;
      step($urandom_range(0, 199) == 0, a, c, $urandom_range(0, 1) == 1);
    end
    hold(2, 4'b0);
    @(negedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      vecs++;
      if (q[d].size() != 0) begin
        miss++;
        $display("FAIL drain dut%0d got=%0d want=0", d, q[d].size());
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule

// File: doc/cdc_sync_edge_multi.md
Name: cdc_sync_edge_multi

Overview:
- Multi-channel successor to the single-bit slow-to-fast pulse synchroniser.
- Takes CH asynchronous level inputs and brings each through a STAGES-deep flop chain into the clk_i domain.
- Optionally debounces each synchronised level, then produces per-channel edge pulses in a selectable mode.
- Holds sticky pending/overflow flags so software or an FSM can consume events at its own pace. Sits at the boundary where external or slow-domain status lines enter a fast core.

Parameters:
- CH, 4, number of independent channels (1..32).
- STAGES, 2, synchroniser depth (>=2).
- EDGE_MODE, 0, pulse qualifier: 0 rising, 1 falling, 2 both.
- FILT_CYC, 4, consecutive stable cycles required before the filtered level changes (1..255). Used only with the filter compiled in.

Ports:
- clk_i  in  1  destination clock
- rst_i  in  1  asynchronous active-high reset
- async_i  in  CH  asynchronous level inputs; no timing relation to clk_i
- clr_i  in  CH  per-channel clear of pending_o/ovf_o; single-cycle or held
- level_o  out  CH  synchronised (and filtered, if enabled) level
- pulse_o  out  CH  one-cycle event pulse per EDGE_MODE
- pending_o  out  CH  sticky: event seen, not yet cleared
- ovf_o  out  CH  sticky: event arrived while pending_o already set

Behaviour:
- Clocking and reset:
  - One clock: clk_i.
  - Reset is asynchronous, active-high: rst_i.
  - While rst_i is high, all flops clear to 0. level_o, pulse_o, pending_o and ovf_o are all 0.
  - Reset mid-operation discards in-flight transitions and flags immediately; no pulse is generated by reset itself.
- Synchroniser:
  - Per channel, a STAGES-flop chain with no logic between stages.
  - async_i is sampled only by stage 1.
- Latency without the filter:
  - An input change captured at edge E0 appears on level_o after edge E0+STAGES-1.
  - Uncertainty is ±1 cycle from the metastability window.
- Edge detection:
  - One delay flop holds level_o from the previous cycle.
  - Rise pulse: level_o & ~prev. Fall pulse: ~level_o & prev.
  - pulse_o is combinational from these registers. It is high exactly in the first cycle that level_o shows its new value, for one cycle only.
- Reset release with input high:
  - If async_i[i] is 1 at reset release, level_o rises after STAGES-1 edges.
  - This produces a rise pulse in mode 0 or 2. This behaviour is required.
- Input toggling faster than clk_i:
  - No guarantee of capture.
  - Each level_o transition yields at most one pulse.
  - In mode 2, consecutive level changes give back-to-back pulses.
- Pending/overflow:
  - pending_o[i] sets on the cycle after pulse_o[i] and clears on the cycle after clr_i[i].
  - ovf_o[i] sets if pulse_o[i] occurs while pending_o[i]=1.
  - Simultaneous pulse and clr: set wins for pending_o; ovf_o clears (no lost event, no stale overflow).
- Channels are fully independent; no cross-channel ordering guarantee.

Optional Feature:
- Macro: CDC_SYNC_FILTER_EN.
- Defined:
  - Per channel, an 8-bit counter compares the last sync stage with the filtered level.
  - Each cycle they differ, the counter increments. When it reaches FILT_CYC-1 while they still differ, the filtered level flips and the counter clears.
  - Any cycle they match clears the counter.
  - Net effect: the synchronised level must differ for FILT_CYC consecutive cycles before level_o changes, adding FILT_CYC cycles of latency.
  - Input pulses shorter than FILT_CYC cycles (after sync) are suppressed.
  - FILT_CYC=1 adds exactly one cycle of latency.
- Undefined: filtered level equals the last sync stage, counters are absent, and FILT_CYC is ignored.

Decomposition:
- Shared package cdc_pkg:
  - EDGE_RISE=0, EDGE_FALL=1, EDGE_BOTH=2.
  - Filter counter width constant (8).
- One sub-module, cdc_sync_edge_ch: a single channel holding the sync chain, optional filter, edge detect and sticky flags.
- The top generates CH instances and concatenates the outputs.

Test Plan:
- CH=4, STAGES=2, mode 0, no filter. async_i[0] 0→1 just before edge 10 -> level_o[0]=1 after edge 11 (±1); pulse_o[0] high one cycle; pending_o[0]=1 next cycle; channels 1-3 stay 0.
- Mode 2. async_i[1] 1→0→1, each level held 5 cycles -> two single-cycle pulses 5 cycles apart; pending_o[1] set; ovf_o[1]=1 after the second pulse.
- Pulse and clr_i[2] in the same cycle with pending_o[2]=1 -> pending_o[2] stays 1, ovf_o[2]=0.
- async_i[3]=1 during reset, rst_i released at edge 20 -> rise pulse at edge 21 (STAGES=2); rst_i asserted mid-chain -> all outputs 0 asynchronously, no pulse after release if the input is then 0.
- CDC_SYNC_FILTER_EN, FILT_CYC=4. 3-cycle glitch on async_i[0] -> no level_o change, no pulse. 6-cycle high -> level_o rises 4 cycles after the synced value, one pulse.
- Mode 1, STAGES=3. async_i[2] 1→0 -> fall pulse 2 edges after capture; rising transitions produce no pulse.
